// File: rtl/rpn_evaluator_if.sv
// rpn_evaluator_if: token-in / result-out handshake bundle for rpn_evaluator.
//   master : the token source / result sink side
//   slave  : the evaluator side
// Signals:
//   in_stb, in_data, in_is_operator  token offered by the source (held until in_ack)
//   in_ack                           one-cycle pulse, token consumed
//   result_stb, result_data, result_err  result offered to the sink (held until result_ack)
//   result_ack                       sink has taken the result
//   depth                            current operand stack occupancy
//   busy                             evaluator is not idle
interface rpn_evaluator_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic             in_stb;
  logic [WIDTH-1:0] in_data;
  logic             in_is_operator;
  logic             in_ack;
  logic             result_stb;
  logic [WIDTH-1:0] result_data;
  logic             result_err;
  logic             result_ack;
  logic [SPW-1:0]   depth;
  logic             busy;

  modport master (
    output in_stb, in_data, in_is_operator, result_ack,
    input  in_ack, result_stb, result_data, result_err, depth, busy
  );

  modport slave (
    input  in_stb, in_data, in_is_operator, result_ack,
    output in_ack, result_stb, result_data, result_err, depth, busy
  );
endinterface

// File: rtl/rpn_evaluator.sv
// rpn_evaluator: evaluates a postfix token stream on an operand stack.
// Numbers are pushed; '*', '+', '-' pop two operands and push the result;
// '=' emits the single remaining operand on the result channel. Any
// malformed token (overflow, underflow, bad opcode, '=' with depth != 1)
// emits an error result and flushes the stack.
// Ports:
//   CLK  clock, all state changes on the rising edge
//   RST  synchronous active-high reset
//   bus  rpn_evaluator_if.slave (token input, result output, depth, busy)
module rpn_evaluator #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input logic           CLK,
  input logic           RST,
  rpn_evaluator_if.slave bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, RES_WAIT, GAP} state_t;

  state_t           state_reg;
  logic [SPW-1:0]   sp_reg;
  logic             in_ack_reg;
  logic             result_stb_reg;
  logic [WIDTH-1:0] result_data_reg;
  logic             result_err_reg;
  logic             busy_reg;

  // Operand registers: the stack is read every cycle at the two top-of-stack
  // addresses, so when an operator is accepted in IDLE both operands are
  // already registered for the EXEC cycle.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;

  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic [SPW-1:0]   sp_m1;
  logic [SPW-1:0]   sp_m2;
  logic [AW-1:0]    idx_top;
  logic [AW-1:0]    idx_below;
  logic             full;
  logic [2:0]       opcode;
  logic             tok_error;
  logic [WIDTH-1:0] alu_result;
  logic             stack_we;
  logic [AW-1:0]    stack_waddr;
  logic [WIDTH-1:0] stack_wdata;

  assign sp_m1     = sp_reg - SPW'(1);
  assign sp_m2     = sp_reg - SPW'(2);
  assign idx_top   = sp_m1[AW-1:0];
  assign idx_below = sp_m2[AW-1:0];
  assign full      = (sp_reg == SPW'(DEPTH));
  assign opcode    = bus.in_data[2:0];

  // Whether the token currently offered would fault in IDLE.
  always_comb begin
    tok_error = 1'b0;
    if (!bus.in_is_operator) begin
      tok_error = full;
    end else begin
      case (opcode)
        OP_MUL, OP_ADD, OP_SUB: tok_error = (sp_reg < SPW'(2));
        OP_EQ:                  tok_error = (sp_reg != SPW'(1));
        default:                tok_error = 1'b1;
      endcase
    end
  end

  always_comb begin
    alu_result = '0;
    case (op_reg)
      OP_MUL:  alu_result = a_reg * b_reg;
      OP_ADD:  alu_result = a_reg + b_reg;
      OP_SUB:  alu_result = a_reg - b_reg;
      default: alu_result = '0;
    endcase
  end

  // Single stack write port: a push in IDLE or the operator result in EXEC.
  always_comb begin
    stack_we    = 1'b0;
    stack_waddr = sp_reg[AW-1:0];
    stack_wdata = bus.in_data;
    if (!RST) begin
      if (state_reg == IDLE && bus.in_stb && !bus.in_is_operator && !full) begin
        stack_we = 1'b1;
      end else if (state_reg == EXEC) begin
        stack_we    = 1'b1;
        stack_waddr = idx_below;
        stack_wdata = alu_result;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (stack_we) begin
      stack_mem[stack_waddr] <= stack_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    a_reg <= stack_mem[idx_below];
    b_reg <= stack_mem[idx_top];
    if (state_reg == IDLE) begin
      op_reg <= opcode;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= IDLE;
      sp_reg          <= '0;
      in_ack_reg      <= 1'b0;
      result_stb_reg  <= 1'b0;
      result_data_reg <= '0;
      result_err_reg  <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_stb) begin
            busy_reg <= 1'b1;
            if (tok_error) begin
              // Fault: report, flush the stack, hold the token until the
              // result has been taken.
              result_data_reg <= '0;
              result_err_reg  <= 1'b1;
              result_stb_reg  <= 1'b1;
              sp_reg          <= '0;
              state_reg       <= RES_WAIT;
            end else if (!bus.in_is_operator) begin
              sp_reg     <= sp_reg + SPW'(1);
              in_ack_reg <= 1'b1;
              state_reg  <= GAP;
            end else if (opcode == OP_EQ) begin
              result_data_reg <= stack_mem[0];
              result_err_reg  <= 1'b0;
              result_stb_reg  <= 1'b1;
              sp_reg          <= '0;
              state_reg       <= RES_WAIT;
            end else begin
              state_reg <= EXEC;
            end
          end
        end
        EXEC: begin
          sp_reg     <= sp_m1;
          in_ack_reg <= 1'b1;
          state_reg  <= GAP;
        end
        RES_WAIT: begin
          if (bus.result_ack) begin
            result_stb_reg <= 1'b0;
            in_ack_reg     <= 1'b1;
            state_reg      <= GAP;
          end
        end
        GAP: begin
          // Dead cycle so the source sees in_ack and drops in_stb before
          // IDLE samples again.
          in_ack_reg <= 1'b0;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ack      = in_ack_reg;
  assign bus.result_stb  = result_stb_reg;
  assign bus.result_data = result_data_reg;
  assign bus.result_err  = result_err_reg;
  assign bus.depth       = sp_reg;
  assign bus.busy        = busy_reg;
endmodule
